// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation codes,
// FSM encoding, iteration count and the divide-by-zero quotient.
package mdu_pkg;

  localparam logic [3:0] ACL_MUL  = 4'b0000;
  localparam logic [3:0] ACL_MULH = 4'b0001;
  localparam logic [3:0] ACL_DIV  = 4'b0100;
  localparam logic [3:0] ACL_REM  = 4'b0110;

  localparam int ITER = 32;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_seq.sv
// Sequential unsigned multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one iteration per clock, fixed 33-cycle latency.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  acl,
  output logic        busy,
  output logic        done,
  output logic [31:0] mulresult
);

  state_t      state;
  state_t      nextstate;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] bop;
  logic [3:0]  op;
  logic        last;

  logic [31:0] addend;
  logic [32:0] sum;
  logic [63:0] prodnext;
  logic [33:0] shifted;
  logic [33:0] diff;
  logic [32:0] remnext;
  logic [31:0] quonext;
  logic [31:0] result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextstate;
    end
  end

  always_comb begin
    nextstate = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextstate = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          nextstate = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        nextstate = IDLE;
      end
      default: nextstate = IDLE;
    endcase
  end

  assign last = (cnt == 5'(ITER - 1));

  // Both datapaths step every iteration; only the latched op picks which one
  // feeds mulresult. A zero divisor naturally leaves rem equal to the dividend.
  always_comb begin
    addend   = prod[0] ? bop : 32'h0;
    sum      = {1'b0, prod[63:32]} + {1'b0, addend};
    prodnext = {sum, prod[31:1]};

    shifted  = {rem, quo[31]};
    diff     = shifted - {2'b00, bop};
    if (diff[33]) begin
      remnext = shifted[32:0];
      quonext = {quo[30:0], 1'b0};
    end else begin
      remnext = diff[32:0];
      quonext = {quo[30:0], 1'b1};
    end

    case (op)
      ACL_MUL:  result = prodnext[31:0];
      ACL_MULH: result = prodnext[63:32];
      ACL_DIV:  result = (bop == 32'h0) ? DIV_ZERO_Q : quonext;
      ACL_REM:  result = remnext[31:0];
      default:  result = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      bop       <= '0;
      op        <= '0;
      mulresult <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            prod <= {32'h0, a};
            quo  <= a;
            rem  <= '0;
            bop  <= b;
            op   <= acl;
            cnt  <= '0;
          end
        end
        RUN: begin
          prod <= prodnext;
          rem  <= remnext;
          quo  <= quonext;
          cnt  <= cnt + 5'd1;
          if (last) begin
            mulresult <= result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed testbench for mdu_seq: each task drives one scenario and checks
// results and latency against hand-computed values.
module tb_mdu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  acl;
  logic        busy;
  logic        done;
  logic [31:0] mulresult;

  int compared;
  int mismatched;

  mdu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .acl       (acl),
    .busy      (busy),
    .done      (done),
    .mulresult (mulresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start for one cycle, then wait (bounded) for done; lat counts
  // negedges from the one where start was raised.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                               input logic [3:0] iacl,
                               output logic [31:0] res, output int lat);
    @(negedge clk);
    a = ia; b = ib; acl = iacl; start = 1'b1;
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    res = mulresult;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; acl = '0;
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
    compared++;
    if (mulresult !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result got %h want 00000000", mulresult); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, res, lat);
    compared++;
    if (res !== 32'h0000_0001) begin mismatched++; $display("[TB] FAIL mul_lo got %h want 00000001", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL mul_latency got %0d want 33", lat); end
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, res, lat);
    compared++;
    if (res !== 32'hFFFF_FFFE) begin mismatched++; $display("[TB] FAIL mulhu got %h want fffffffe", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL mulhu_latency got %0d want 33", lat); end
  endtask

  task automatic test_div();
    logic [31:0] res;
    int lat;
    applyStimulus(32'd100, 32'd7, 4'b0100, res, lat);
    compared++;
    if (res !== 32'd14) begin mismatched++; $display("[TB] FAIL divu got %0d want 14", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL divu_latency got %0d want 33", lat); end
    applyStimulus(32'd100, 32'd7, 4'b0110, res, lat);
    compared++;
    if (res !== 32'd2) begin mismatched++; $display("[TB] FAIL remu got %0d want 2", res); end
    applyStimulus(32'h8000_0000, 32'd1, 4'b0100, res, lat);
    compared++;
    if (res !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL divu_msb got %h want 80000000", res); end
  endtask

  task automatic test_divzero();
    logic [31:0] res;
    int lat;
    applyStimulus(32'h0000_1234, 32'h0, 4'b0100, res, lat);
    compared++;
    if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL divu_zero got %h want ffffffff", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL divu_zero_latency got %0d want 33", lat); end
    applyStimulus(32'h0000_1234, 32'h0, 4'b0110, res, lat);
    compared++;
    if (res !== 32'h0000_1234) begin mismatched++; $display("[TB] FAIL remu_zero got %h want 00001234", res); end
    compared++;
    if ($isunknown({busy, done, mulresult})) begin
      mismatched++; $display("[TB] FAIL divzero_no_x got %b%b%h want no X", busy, done, mulresult);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res;
    int lat;
    applyStimulus(32'd5, 32'd3, 4'b0010, res, lat);
    compared++;
    if (res !== 32'h0) begin mismatched++; $display("[TB] FAIL illegal_acl got %h want 00000000", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL illegal_latency got %0d want 33", lat); end
  endtask

  task automatic test_ignore_start();
    int dones;
    int firstcyc;
    logic [31:0] res;
    dones = 0; firstcyc = -1; res = '0;
    @(negedge clk);
    a = 32'h0000_1234; b = 32'h0000_0010; acl = 4'b0000; start = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 5 || cyc == 20) begin
        a = 32'h0000_0007; b = 32'h0000_0009; acl = 4'b0001; start = 1'b1;
      end
      if (cyc == 10) begin
        compared++;
        if (mulresult !== 32'h0) begin mismatched++; $display("[TB] FAIL hold_midrun got %h want 00000000", mulresult); end
      end
      if (done === 1'b1) begin
        dones++;
        if (firstcyc < 0) begin
          firstcyc = cyc;
          res = mulresult;
        end
      end
    end
    compared++;
    if (dones !== 1) begin mismatched++; $display("[TB] FAIL ignore_done_count got %0d want 1", dones); end
    compared++;
    if (firstcyc !== 33) begin mismatched++; $display("[TB] FAIL ignore_latency got %0d want 33", firstcyc); end
    compared++;
    if (res !== 32'h0001_2340) begin mismatched++; $display("[TB] FAIL ignore_result got %h want 00012340", res); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    int lat;
    int dones;
    @(negedge clk);
    a = 32'd1000; b = 32'd3; acl = 4'b0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done got %b want 0", done); end
    compared++;
    if (mulresult !== 32'h0) begin mismatched++; $display("[TB] FAIL abort_result got %h want 00000000", mulresult); end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    compared++;
    if (dones !== 0) begin mismatched++; $display("[TB] FAIL abort_no_done got %0d want 0", dones); end
    applyStimulus(32'd3, 32'd5, 4'b0000, res, lat);
    compared++;
    if (res !== 32'd15) begin mismatched++; $display("[TB] FAIL post_reset_mul got %0d want 15", res); end
    compared++;
    if (lat !== 33) begin mismatched++; $display("[TB] FAIL post_reset_latency got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res1;
    logic [31:0] res2;
    int lat1;
    int lat2;
    applyStimulus(32'h0001_0000, 32'h0001_0000, 4'b0000, res1, lat1);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 4'b0001, res2, lat2);
    compared++;
    if (res1 !== 32'h0) begin mismatched++; $display("[TB] FAIL b2b_first got %h want 00000000", res1); end
    compared++;
    if (res2 !== 32'h0000_0001) begin mismatched++; $display("[TB] FAIL b2b_second got %h want 00000001", res2); end
    compared++;
    if (lat1 !== 33 || lat2 !== 33) begin
      mismatched++; $display("[TB] FAIL b2b_latency got %0d/%0d want 33/33", lat1, lat2);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_done_clear got %b want 0", done); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_illegal();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
